// File: rtl/k12a_skip_sequencer_pkg.sv
// Shared types for the k12a skip sequencer: skip-register select codes,
// sequencer FSM states and a small instruction-length helper.
`timescale 1ns/1ps
package k12a_skip_sequencer_pkg;

   // Next-value select for the external skip register
   typedef enum logic [1:0] {
      HOLD        = 2'd0,
      SKIP_SEL_0  = 2'd1,
      CONDITION   = 2'd2,
      CONDITION_N = 2'd3
   } skip_sel_t;

   // Sequencer states
   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      EXECUTE = 2'd1,
      DISCARD = 2'd2
   } seq_state_t;

   // A length code of zero is treated as a one-word instruction
   function automatic logic [1:0] norm_len(input logic [1:0] len);
      return (len == 2'd0) ? 2'd1 : len;
   endfunction

endpackage

// File: rtl/k12a_skip_sequencer.sv
// k12a skip sequencer: fetches instruction words, commits or squashes each
// instruction depending on the registered skip flag, and discards the
// operand words of squashed multi-word instructions.
`timescale 1ns/1ps
module k12a_skip_sequencer
   import k12a_skip_sequencer_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             cpu_clock,
   input  logic             reset,
   output logic             fetch_req,
   input  logic             word_valid,
   input  logic [1:0]       insn_len,
   input  logic             insn_is_skip,
   input  logic             skip_polarity,
   input  logic             alu_condition,
   input  logic             skip,
   output skip_sel_t        skip_sel,
   output logic             exec_en,
   output logic [CNT_W-1:0] squash_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   seq_state_t       state_q, state_d;
   logic [1:0]       rem_q,   rem_d;
   logic [1:0]       len_q,   len_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;

   // State register: all sequencer state, asynchronously cleared by reset
   always_ff @(posedge cpu_clock or posedge reset) begin
      if (reset) begin
         state_q <= FETCH;
         rem_q   <= 2'd0;
         len_q   <= 2'd1;
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic: fetch, one-cycle execute/squash, operand discard
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      case (state_q)
         FETCH: begin
            if (word_valid) begin
               state_d = EXECUTE;
               len_d   = norm_len(insn_len);
            end else begin
               state_d = FETCH;
            end
         end
         EXECUTE: begin
            if (skip) begin
               // Squash: count it (saturating) and drop any operand words
               cnt_d = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
               if (len_q > 2'd1) begin
                  state_d = DISCARD;
                  rem_d   = len_q - 2'd1;
               end else begin
                  state_d = FETCH;
               end
            end else begin
               // Operand words of executed instructions belong to the decoder
               state_d = FETCH;
            end
         end
         DISCARD: begin
            if (word_valid) begin
               if (rem_q <= 2'd1) begin
                  state_d = FETCH;
                  rem_d   = 2'd0;
               end else begin
                  rem_d   = rem_q - 2'd1;
               end
            end else begin
               state_d = DISCARD;
            end
         end
         default: begin
            state_d = FETCH;
            rem_d   = 2'd0;
         end
      endcase
   end

   // Output decode: fetch request, commit strobe and skip-register select
   always_comb begin
      fetch_req = 1'b0;
      exec_en   = 1'b0;
      skip_sel  = HOLD;
      case (state_q)
         FETCH: begin
            fetch_req = 1'b1;
         end
         EXECUTE: begin
            if (skip) begin
               // A squashed skip instruction must not re-arm the skip flag
               skip_sel = SKIP_SEL_0;
            end else begin
               exec_en = 1'b1;
               if (insn_is_skip) begin
                  skip_sel = skip_polarity ? CONDITION_N : CONDITION;
               end else begin
                  skip_sel = SKIP_SEL_0;
               end
            end
         end
         DISCARD: begin
            fetch_req = 1'b1;
         end
         default: begin
            fetch_req = 1'b1;
         end
      endcase
   end

   assign squash_count = cnt_q;

endmodule

// File: tb/tb_k12a_skip_sequencer.sv
// Bench for k12a_skip_sequencer: drives whole instructions with random word
// gaps, models the external skip register, and predicts each instruction's
// outcome (commit or squash, words consumed, counter, skip flag).
`timescale 1ns/1ps
module tb_k12a_skip_sequencer;
   import k12a_skip_sequencer_pkg::*;

   localparam int CNT_W   = 8;
   localparam int CNT_SAT = (1 << CNT_W) - 1;

   logic             cpu_clock = 1'b0;
   logic             reset = 1'b1;
   logic             fetch_req;
   logic             word_valid = 1'b0;
   logic [1:0]       insn_len = 2'd1;
   logic             insn_is_skip = 1'b0;
   logic             skip_polarity = 1'b0;
   logic             alu_condition = 1'b0;
   logic             skip_r;
   skip_sel_t        skip_sel;
   logic             exec_en;
   logic [CNT_W-1:0] squash_count;

   int n_checks = 0;
   int n_pass   = 0;
   int exec_pulses = 0;

   // Reference model state (instruction level)
   bit m_skip  = 1'b0;
   int m_cnt   = 0;
   int m_pulses = 0;

   k12a_skip_sequencer #(.CNT_W(CNT_W)) dut (
      .cpu_clock     (cpu_clock),
      .reset         (reset),
      .fetch_req     (fetch_req),
      .word_valid    (word_valid),
      .insn_len      (insn_len),
      .insn_is_skip  (insn_is_skip),
      .skip_polarity (skip_polarity),
      .alu_condition (alu_condition),
      .skip          (skip_r),
      .skip_sel      (skip_sel),
      .exec_en       (exec_en),
      .squash_count  (squash_count)
   );

   always #5 cpu_clock = ~cpu_clock;

   // The skip register the sequencer drives
   always_ff @(posedge cpu_clock or posedge reset) begin
      if (reset) begin
         skip_r <= 1'b0;
      end else begin
         case (skip_sel)
            HOLD:        skip_r <= skip_r;
            SKIP_SEL_0:  skip_r <= 1'b0;
            CONDITION:   skip_r <= alu_condition;
            CONDITION_N: skip_r <= ~alu_condition;
            default:     skip_r <= skip_r;
         endcase
      end
   end

   // Count commit strobes seen on clock edges
   always @(posedge cpu_clock) begin
      if (!reset && exec_en) exec_pulses <= exec_pulses + 1;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic do_reset();
      @(negedge cpu_clock);
      reset = 1'b1;
      word_valid = 1'b0;
      #1;
      check_val("rst_fetch_req", fetch_req, 32'd1);
      check_val("rst_exec_en", exec_en, 32'd0);
      check_val("rst_skip_sel", skip_sel, HOLD);
      check_val("rst_squash_count", squash_count, 32'd0);
      @(negedge cpu_clock);
      reset = 1'b0;
      m_skip = 1'b0;
      m_cnt = 0;
   endtask

   // Run one instruction; optionally reset on the first discard cycle
   task automatic run_insn(input logic [1:0] len, input bit is_skip, input bit pol,
                           input bit cond, input bit abort_discard);
      int        eff;
      int        rem;
      bit        squash;
      bit        got;
      bit        exp_exec;
      skip_sel_t exp_sel;
      eff    = (len == 2'd0) ? 1 : int'(len);
      squash = m_skip;
      exp_exec = !squash;
      if (squash)       exp_sel = SKIP_SEL_0;
      else if (!is_skip) exp_sel = SKIP_SEL_0;
      else              exp_sel = pol ? CONDITION_N : CONDITION;

      @(negedge cpu_clock);
      insn_len = len;
      insn_is_skip = is_skip;
      skip_polarity = pol;
      alu_condition = cond;
      got = 1'b0;
      for (int t = 0; t < 16 && !got; t++) begin
         #1;
         check_val("fetch_req_F", fetch_req, 32'd1);
         check_val("exec_en_F", exec_en, 32'd0);
         word_valid = (t >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
         got = word_valid && fetch_req;
         @(negedge cpu_clock);
      end
      if (!got) check_val("fetch_timeout", 32'd0, 32'd1);

      // Execute cycle: a stray word here must be ignored
      word_valid = 1'($urandom_range(0, 1));
      #1;
      check_val("exec_fetch_req", fetch_req, 32'd0);
      check_val("exec_en_E", exec_en, {31'd0, exp_exec});
      check_val("exec_skip_sel", skip_sel, exp_sel);
      if (exp_exec) m_pulses++;
      if (squash) begin
         if (m_cnt < CNT_SAT) m_cnt++;
         m_skip = 1'b0;
         rem = eff - 1;
      end else begin
         m_skip = is_skip ? (cond ^ pol) : 1'b0;
         rem = 0;
      end
      @(negedge cpu_clock);

      if (abort_discard && rem > 0) begin
         reset = 1'b1;
         word_valid = 1'b0;
         #1;
         check_val("abort_fetch_req", fetch_req, 32'd1);
         check_val("abort_exec_en", exec_en, 32'd0);
         check_val("abort_skip_sel", skip_sel, HOLD);
         check_val("abort_squash_count", squash_count, 32'd0);
         @(negedge cpu_clock);
         reset = 1'b0;
         m_skip = 1'b0;
         m_cnt = 0;
         @(negedge cpu_clock);
         check_val("abort_no_pulse", exec_pulses, m_pulses);
         check_val("abort_fetch_after", fetch_req, 32'd1);
         return;
      end

      for (int t = 0; t < 16 && rem > 0; t++) begin
         #1;
         check_val("discard_fetch_req", fetch_req, 32'd1);
         check_val("discard_exec_en", exec_en, 32'd0);
         check_val("discard_skip_sel", skip_sel, HOLD);
         word_valid = (t >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
         if (word_valid && fetch_req) rem--;
         @(negedge cpu_clock);
      end
      if (rem != 0) check_val("discard_timeout", 32'd0, 32'd1);

      word_valid = 1'b0;
      #1;
      check_val("end_fetch_req", fetch_req, 32'd1);
      check_val("end_squash_count", squash_count, m_cnt);
      check_val("end_skip", skip_r, {31'd0, m_skip});
      check_val("end_exec_pulses", exec_pulses, m_pulses);
   endtask

   initial begin
      do_reset();

      // One-word plain instruction executes
      run_insn(2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      // Skip armed (polarity 0, condition true), then a squashed 1-word insn
      run_insn(2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
      run_insn(2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      // Skip armed, then a squashed 3-word insn
      run_insn(2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
      run_insn(2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      run_insn(2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      // Skip armed, then a squashed skip insn; the following one executes
      run_insn(2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
      run_insn(2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
      run_insn(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Random instruction mix
      for (int i = 0; i < 300; i++) begin
         run_insn(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      end

      // Counter saturation: 256 squashes from zero
      do_reset();
      for (int i = 0; i < CNT_SAT + 1; i++) begin
         run_insn(2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
         run_insn(2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      check_val("sat_hold", squash_count, 32'hFF);

      // Reset in DISCARD with one word left
      run_insn(2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
      run_insn(2'd2, 1'b0, 1'b0, 1'b0, 1'b1);
      run_insn(2'd1, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/k12a_skip_sequencer.md
K12A_SKIP_SEQUENCER -- requirements
Module: k12a_skip_sequencer

Interface
REQ-001 Parameter: CNT_W, default 8, width of the squashed-instruction counter.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 cpu_clock  input  1  CPU clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 fetch_req  output  1  requests the next instruction word.
REQ-006 word_valid  input  1  fetched word present; consumed only when fetch_req=1.
REQ-007 insn_len  input  2  word count of the current instruction (1..3); 0 is treated as 1.
REQ-008 insn_is_skip  input  1  current instruction is a conditional-skip instruction.
REQ-009 skip_polarity  input  1  0 = skip if condition true, 1 = skip if condition false.
REQ-010 alu_condition  input  1  condition result for the current instruction.
REQ-011 skip  input  1  registered skip flag from the skip register.
REQ-012 skip_sel  output  skip_sel_t  next-value select driven to the skip register.
REQ-013 exec_en  output  1  commit strobe for the current instruction's side effects.
REQ-014 squash_count  output  CNT_W  saturating count of squashed instructions.

Function
REQ-015 The FSM SHALL have the states FETCH, EXECUTE and DISCARD.
REQ-016 FETCH: fetch_req=1, exec_en=0, skip_sel=HOLD; on word_valid go to EXECUTE and latch insn_len.
REQ-017 EXECUTE lasts exactly one cycle, with fetch_req=0.
- If skip=0: exec_en=1; skip_sel=CONDITION_N when insn_is_skip and skip_polarity=1, CONDITION when insn_is_skip and skip_polarity=0, otherwise SKIP_SEL_0.
REQ-018 EXECUTE with skip=1 (squash): exec_en=0, skip_sel=SKIP_SEL_0, and squash_count increments.
- alu_condition and insn_is_skip are ignored, so a skipped skip-instruction never arms a new skip.
REQ-019 Exit from EXECUTE: go to DISCARD with remaining = latched_len-1 if squashed and latched_len>1; otherwise go to FETCH.
REQ-020 Non-squashed multi-word instructions are not handled here; the decoder consumes their operand words.
REQ-021 DISCARD: fetch_req=1, exec_en=0, skip_sel=HOLD; each word_valid decrements remaining; after the last word go to FETCH.
REQ-022 The remaining-words counter SHALL be 2 bits wide; it SHALL never underflow, and DISCARD is never entered with remaining=0.
REQ-023 squash_count SHALL saturate at all-ones and never wrap.
REQ-024 word_valid outside FETCH/DISCARD SHALL be ignored.
REQ-025 Latency: a non-skipped 1-word instruction takes 2 cycles from the FETCH entry edge to the return to FETCH; a squashed n-word instruction takes 1+1+(n-1) cycles with zero-wait fetch.
REQ-026 skip_sel SHALL never be HOLD in EXECUTE; the skip flag is therefore always defined after every executed instruction.

Reset
REQ-027 Reset asserted SHALL immediately force state=FETCH, remaining=0, latched_len=1 and squash_count=0.
REQ-028 Output values during and after reset: fetch_req=1, exec_en=0, skip_sel=HOLD.
REQ-029 Reset mid-DISCARD or mid-EXECUTE SHALL abandon the instruction with no exec_en pulse.

Structure
REQ-030 skip_sel_t (HOLD, SKIP_SEL_0, CONDITION, CONDITION_N; 2-bit) and the state enum SHALL live in the shared k12a package include.
REQ-031 The block SHALL be a single module with no sub-modules; it drives the existing skip register directly.

Verification
REQ-032 Reset, then a 1-word non-skip instruction with word_valid=1 -> EXECUTE next cycle, exec_en=1 for one cycle, skip_sel=SKIP_SEL_0.
REQ-033 Skip instruction, polarity=0, alu_condition=1; then a 1-word instruction -> second instruction has exec_en=0, squash_count=1, skip cleared.
REQ-034 Skip armed, then a 3-word instruction -> exactly 2 extra words consumed in DISCARD; exec_en stays 0; next FETCH is the following instruction.
REQ-035 Skip armed, then a skip instruction with alu_condition=1 -> squashed, skip=0 afterwards, next instruction executes.
REQ-036 255 consecutive squashes followed by one more (CNT_W=8) -> squash_count holds at 8'hFF.
REQ-037 Reset asserted in DISCARD with remaining=1 -> state=FETCH, squash_count=0, no exec_en pulse.
